// File: rtl/cosim_data_arbiter_if.sv
// Requester-side and device-side signal bundle for cosim_data_arbiter.
// Modport master is the arbiter's view; modport slave is the view of requesters plus the data device.
interface cosim_data_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int SEL_W  = 12,
    parameter int DATA_W = 64
);
    // Handshakes: a request transfers on a cycle where req_valid[i] && req_ready[i];
    // a device read transfers on a posedge where dev_read_ready && dev_read_valid.
    // req_ready and resp_valid are single-cycle one-hot pulses; the requester holds
    // req_valid and its select stable until it sees req_ready.
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*SEL_W-1:0] req_select;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       resp_valid;
    logic [DATA_W-1:0]     resp_data;
    logic                  resp_err;
    logic                  dev_read_ready;
    logic [SEL_W-1:0]      dev_read_select;
    logic                  dev_read_valid;
    logic [DATA_W-1:0]     dev_read_data;
    logic                  busy;

    modport master (
        input  req_valid, req_select, dev_read_valid, dev_read_data,
        output req_ready, resp_valid, resp_data, resp_err,
               dev_read_ready, dev_read_select, busy
    );

    modport slave (
        output req_valid, req_select, dev_read_valid, dev_read_data,
        input  req_ready, resp_valid, resp_data, resp_err,
               dev_read_ready, dev_read_select, busy
    );
endinterface

// File: rtl/cosim_data_arbiter.sv
// Round-robin arbiter sharing the single cosim data-device read port among NREQ requesters.
// Optional ISSUE-state timeout is compiled in when COSIM_ARB_TIMEOUT_EN is defined.
module cosim_data_arbiter #(
    parameter int NREQ     = 4,
    parameter int SEL_W    = 12,
    parameter int DATA_W   = 64,
    parameter int RESP_LAT = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    cosim_data_arbiter_if.master bus,
    output logic [1:0]           o_dbg_state
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int LAT_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
`ifdef COSIM_ARB_TIMEOUT_EN
    localparam int TO_W  = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
`endif

    if (NREQ < 1 || NREQ > 16 || RESP_LAT < 1 || TIMEOUT < 1) begin : g_param_check
        $error("cosim_data_arbiter: illegal parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  r_gnt_idx;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic [SEL_W-1:0]  r_sel;
    logic [DATA_W-1:0] r_resp_data;
    logic [NREQ-1:0]   r_resp_valid;
    logic              r_dev_read_ready;
    logic              r_busy;
`ifdef COSIM_ARB_TIMEOUT_EN
    logic              r_resp_err;
    logic [TO_W-1:0]   r_to_cnt;
`endif

    logic              w_found;
    logic [IDX_W-1:0]  w_win;
    logic [SEL_W-1:0]  w_win_sel;
    logic [NREQ-1:0]   w_req_ready;
    logic [NREQ-1:0]   w_gnt_onehot;
    logic [IDX_W-1:0]  w_rr_next;

    // Scan req_valid from rr_ptr upward, wrapping modulo NREQ; the first set bit wins.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] cand;
        idx     = 0;
        cand    = '0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = IDX_W'(idx);
            if (!w_found && bus.req_valid[cand]) begin
                w_found = 1'b1;
                w_win   = cand;
            end
        end
    end

    always_comb begin
        w_win_sel    = '0;
        w_req_ready  = '0;
        w_gnt_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IDX_W'(i)) w_win_sel = bus.req_select[i*SEL_W +: SEL_W];
            w_req_ready[i]  = (r_state == ST_IDLE) && w_found && (w_win == IDX_W'(i));
            w_gnt_onehot[i] = (r_gnt_idx == IDX_W'(i));
        end
    end

    assign w_rr_next = (r_gnt_idx == IDX_W'(NREQ - 1)) ? '0 : r_gnt_idx + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_rr_ptr         <= '0;
            r_gnt_idx        <= '0;
            r_lat_cnt        <= '0;
            r_sel            <= '0;
            r_resp_data      <= '0;
            r_resp_valid     <= '0;
            r_dev_read_ready <= 1'b0;
            r_busy           <= 1'b0;
`ifdef COSIM_ARB_TIMEOUT_EN
            r_resp_err       <= 1'b0;
            r_to_cnt         <= '0;
`endif
        end else begin
            r_resp_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt_idx        <= w_win;
                        r_sel            <= w_win_sel;
                        r_dev_read_ready <= 1'b1;
                        r_busy           <= 1'b1;
                        r_state          <= ST_ISSUE;
`ifdef COSIM_ARB_TIMEOUT_EN
                        r_to_cnt         <= '0;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (bus.dev_read_valid) begin
                        r_dev_read_ready <= 1'b0;
                        r_lat_cnt        <= LAT_W'(RESP_LAT - 1);
                        r_state          <= ST_WAIT;
                    end
`ifdef COSIM_ARB_TIMEOUT_EN
                    // Device never answered: return an error response instead of hanging.
                    else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                        r_dev_read_ready <= 1'b0;
                        r_resp_data      <= '0;
                        r_resp_err       <= 1'b1;
                        r_resp_valid     <= w_gnt_onehot;
                        r_state          <= ST_RESP;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                ST_WAIT: begin
                    // Device data changes on the falling edge, so it is only good RESP_LAT cycles later.
                    if (r_lat_cnt == '0) begin
                        r_resp_data  <= bus.dev_read_data;
                        r_resp_valid <= w_gnt_onehot;
                        r_state      <= ST_RESP;
`ifdef COSIM_ARB_TIMEOUT_EN
                        r_resp_err   <= 1'b0;
`endif
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    r_rr_ptr <= w_rr_next;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready       = w_req_ready;
    assign bus.resp_valid      = r_resp_valid;
    assign bus.resp_data       = r_resp_data;
    assign bus.dev_read_ready  = r_dev_read_ready;
    assign bus.dev_read_select = r_dev_read_ready ? r_sel : '0;
    assign bus.busy            = r_busy;
`ifdef COSIM_ARB_TIMEOUT_EN
    assign bus.resp_err        = r_resp_err;
`else
    assign bus.resp_err        = 1'b0;
`endif
    assign o_dbg_state         = r_state;
endmodule

// File: doc/cosim_data_arbiter.md
Name: cosim_data_arbiter

Overview:
- Shares the single cosim randomizer data-device read port (12-bit select, 64-bit data) among NREQ requesters, e.g. multiple load units or harts that fetch randomized device data.
- Sits between requesters and the data-device blackbox.
- Performs round-robin arbitration, sequences one device read at a time and routes the response back to the granted requester.
- Device returns data RESP_LAT cycles after the read handshake, because the device updates its data on the falling edge.

Parameters:
- NREQ, 4, number of requesters (1..16)
- SEL_W, 12, read-select width
- DATA_W, 64, read-data width
- RESP_LAT, 1, cycles from device handshake to valid dev_read_data (>=1)
- TIMEOUT, 255, ISSUE-state cycle limit (used only with the optional feature)

Ports:
- clock  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  NREQ  per-requester read request
- req_select  in  NREQ*SEL_W  per-requester select; slice i = bits [i*SEL_W +: SEL_W]
- req_ready  out  NREQ  one-hot accept pulse
- resp_valid  out  NREQ  one-hot, one-cycle response strobe
- resp_data  out  DATA_W  response data, shared by all requesters
- resp_err  out  1  response is a timeout error; valid with resp_valid
- dev_read_ready  out  1  to device read_ready
- dev_read_select  out  SEL_W  to device read_select
- dev_read_valid  in  1  from device read_valid
- dev_read_data  in  DATA_W  from device read_data
- busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high): state=IDLE, rr_ptr=0, gnt_idx=0, lat_cnt=0. resp_data, resp_err, resp_valid, dev_read_ready, dev_read_select and busy are all 0.
- Reset mid-transaction aborts the transaction; no resp_valid is produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Scan req_valid starting at rr_ptr, wrapping modulo NREQ.
  - First set bit wins: req_ready[winner]=1 in the same cycle (combinational from req_valid, only in IDLE).
  - Latch gnt_idx and that requester's select, then go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - dev_read_ready=1; dev_read_select=latched select.
  - On a posedge with dev_read_valid=1: handshake completes, lat_cnt=RESP_LAT-1, go to WAIT.
- WAIT:
  - dev_read_ready=0.
  - If lat_cnt==0: capture dev_read_data into resp_data, resp_err=0, go to RESP.
  - Otherwise decrement lat_cnt.
- RESP:
  - resp_valid[gnt_idx]=1 for exactly one cycle.
  - rr_ptr=(gnt_idx+1) mod NREQ; go to IDLE.
  - resp_data holds its value until the next capture.
- Throughput: one transaction per RESP_LAT+3 cycles when the device is always valid.
- Requester rules:
  - Hold req_valid and the select stable until req_ready is seen.
  - req_valid is sampled only in IDLE.
  - Deasserting req_valid before grant is legal and yields no response.
- A new request arriving during RESP is not granted until the following IDLE cycle.
- NREQ=1: rr_ptr stays 0.
- Wrap-around: gnt_idx=NREQ-1 sets rr_ptr to 0.
- Exactly one requester is ever granted; req_ready and resp_valid are never multi-hot.

Optional Feature:
- Macro: COSIM_ARB_TIMEOUT_EN.
- With the macro:
  - An 8-bit-or-wider counter clears on entry to ISSUE and increments each ISSUE cycle.
  - If it reaches TIMEOUT with no handshake: drop dev_read_ready, set resp_data=0 and resp_err=1, go to RESP (resp_valid still pulses).
- Without the macro:
  - ISSUE waits indefinitely.
  - resp_err is tied to 0.
  - No counter logic is present.

Test Plan:
- Single request: req_valid[2]=1, select 0x0A5, device always valid, dev_read_data=0xDEAD_BEEF_0000_0001, RESP_LAT=1.
  - req_ready[2] in cycle 0.
  - dev_read_ready with select 0x0A5 in cycle 1.
  - resp_valid[2] with that data in cycle 3.
- All four requesters held valid from reset: grant order 0,1,2,3,0.
  - Each resp_valid is one-hot, 4 cycles apart.
- rr_ptr wrap: grant requester 3 alone, then assert requesters 0 and 3 together -> 0 is granted first.
- Device backpressure: dev_read_valid=0 for 5 cycles in ISSUE.
  - dev_read_ready stays 1 with a stable select.
  - The response arrives 2 cycles after valid rises.
  - No other requester is granted meanwhile.
- Reset asserted during WAIT.
  - Next cycle: all outputs 0, no resp_valid.
  - A fresh request afterwards completes normally with rr_ptr=0.
- COSIM_ARB_TIMEOUT_EN with TIMEOUT=8 and dev_read_valid stuck at 0.
  - resp_valid[i] with resp_data=0 and resp_err=1 about 9 cycles after grant.
  - FSM returns to IDLE.
